// File: rtl/shared_sched_pkg.sv
// Shared types and defaults for the shared-resource round-robin scheduler.
package shared_sched_pkg;

  typedef enum logic {SCHED_IDLE, SCHED_GRANT} sched_state_t;

  localparam int DEFAULT_MAX_BURST    = 4;
  localparam int DEFAULT_STARVE_LIMIT = 8;

  // Successor of lane k in a ring of n lanes.
  function automatic int unsigned rr_next(input int unsigned k, input int unsigned n);
    return (k + 1 >= n) ? 0 : k + 1;
  endfunction

endpackage

// File: rtl/shared_resource_scheduler_rr_pick.sv
// Combinational round-robin picker: first candidate at or after rr_ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   rr_ptr,
  input  logic [NUM_REQ-1:0] exclude,
  output logic               found,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx
);

  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] at_or_after;
  logic [NUM_REQ-1:0] upper;
  logic [NUM_REQ-1:0] scan;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_window
    assign at_or_after[gi] = (IDX_W'(gi) >= rr_ptr);
  end

  // Lanes from rr_ptr upward take priority; otherwise wrap to the lowest lane.
  assign cand   = eligible & ~exclude;
  assign upper  = cand & at_or_after;
  assign scan   = (|upper) ? upper : cand;
  assign onehot = scan & (~scan + NUM_REQ'(1));
  assign found  = |cand;

  for (genvar gb = 0; gb < IDX_W; gb++) begin : g_idx_bit
    logic [NUM_REQ-1:0] bit_mask;
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign bit_mask[gi] = (((gi >> gb) % 2) == 1);
    end
    assign idx[gb] = |(onehot & bit_mask);
  end

endmodule

// File: rtl/shared_resource_scheduler.sv
// Round-robin owner of the shared resource: registered grant, burst quota,
// flush-driven release and per-lane starvation monitoring.
module shared_resource_scheduler
  import shared_sched_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int MAX_BURST    = DEFAULT_MAX_BURST,
  parameter int WAIT_W       = 4,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         hold,
  input  logic [NUM_REQ-1:0]         flush,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic [NUM_REQ-1:0]         starve,
  output logic [15:0]                grant_count
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  sched_state_t       state_reg, state_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [IDX_W-1:0]   grant_idx_reg, grant_idx_next;
  logic [BURST_W-1:0] burst_reg, burst_next;
  logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [15:0]        grant_count_reg, grant_count_next;
  logic [NUM_REQ-1:0] starve_reg;

  logic [NUM_REQ-1:0] eligible;
  logic               pick_found;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               owner_req, owner_hold, owner_flush;
  logic               release_owner;
  logic               new_grant;

  assign eligible = req & ~flush;

  // Excluding the current owner serves both idle (grant is zero) and hand-off.
  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_reg),
    .exclude  (grant_reg),
    .found    (pick_found),
    .onehot   (pick_onehot),
    .idx      (pick_idx)
  );

  assign owner_req   = |(req & grant_reg);
  assign owner_hold  = |(hold & grant_reg);
  assign owner_flush = |(flush & grant_reg);

  // pick_found here means some lane other than the owner is eligible.
  assign release_owner = owner_flush
                       | (~owner_req & ~owner_hold)
                       | ((burst_reg == BURST_MAX) & ~owner_hold & pick_found);

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    grant_idx_next = grant_idx_reg;
    burst_next     = burst_reg;
    rr_ptr_next    = rr_ptr_reg;
    new_grant      = 1'b0;
    case (state_reg)
      SCHED_IDLE: begin
        if (pick_found) begin
          state_next = SCHED_GRANT;
          new_grant  = 1'b1;
        end
      end
      SCHED_GRANT: begin
        if (release_owner) begin
          if (pick_found) begin
            new_grant = 1'b1;
          end else begin
            state_next     = SCHED_IDLE;
            grant_next     = '0;
            grant_idx_next = '0;
            burst_next     = '0;
          end
        end else if (burst_reg != BURST_MAX) begin
          burst_next = burst_reg + BURST_W'(1);
        end
      end
      default: state_next = SCHED_IDLE;
    endcase
    if (new_grant) begin
      grant_next     = pick_onehot;
      grant_idx_next = pick_idx;
      burst_next     = BURST_W'(1);
      rr_ptr_next    = IDX_W'(rr_next(32'(pick_idx), NUM_REQ));
    end
    grant_count_next = grant_count_reg + 16'(new_grant);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= SCHED_IDLE;
      grant_reg       <= '0;
      grant_idx_reg   <= '0;
      burst_reg       <= '0;
      rr_ptr_reg      <= '0;
      grant_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      grant_reg       <= grant_next;
      grant_idx_reg   <= grant_idx_next;
      burst_reg       <= burst_next;
      rr_ptr_reg      <= rr_ptr_next;
      grant_count_reg <= grant_count_next;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_wait
    logic [WAIT_W-1:0] wait_reg, wait_next;
    logic              starve_bit_reg;

    always_comb begin
      wait_next = wait_reg;
      if (!req[gi] || flush[gi] || (grant_next[gi] && !grant_reg[gi])) begin
        wait_next = '0;
      end else if (!grant_reg[gi] && (wait_reg != '1)) begin
        wait_next = wait_reg + WAIT_W'(1);
      end
    end

    // Starve flag tracks the registered wait count in the same cycle.
    always_ff @(posedge clk) begin
      if (reset) begin
        wait_reg       <= '0;
        starve_bit_reg <= 1'b0;
      end else begin
        wait_reg       <= wait_next;
        starve_bit_reg <= (wait_next >= WAIT_W'(STARVE_LIMIT));
      end
    end

    assign starve_reg[gi] = starve_bit_reg;
  end

  assign grant       = grant_reg;
  assign grant_valid = |grant_reg;
  assign grant_idx   = grant_idx_reg;
  assign starve      = starve_reg;
  assign grant_count = grant_count_reg;

endmodule

// File: tb/tb_shared_resource_scheduler.sv
// Directed bench for shared_resource_scheduler with a cycle-level reference model.
module tb_shared_resource_scheduler;

  localparam int N    = 2;
  localparam int MAXB = 4;
  localparam int LIM  = 8;
  localparam int WMAX = 15;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req, hold, flush;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [0:0]   grant_idx;
  logic [N-1:0] starve;
  logic [15:0]  grant_count;

  always #5 clk = ~clk;

  shared_resource_scheduler #(
    .NUM_REQ      (N),
    .MAX_BURST    (MAXB),
    .WAIT_W       (4),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .hold        (hold),
    .flush       (flush),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .starve      (starve),
    .grant_count (grant_count)
  );

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  // Model state: owner lane (-1 when idle), burst length, rotation pointer, counters.
  int m_owner = -1;
  int m_burst = 0;
  int m_ptr   = 0;
  int m_cnt   = 0;
  int m_wait [N];

  localparam logic [5:0] MIX [20] = '{
    6'b11_00_00, 6'b11_01_00, 6'b11_01_00, 6'b11_01_00, 6'b11_01_00,
    6'b11_01_00, 6'b11_00_00, 6'b01_10_00, 6'b01_10_00, 6'b01_10_10,
    6'b10_00_01, 6'b10_00_00, 6'b00_10_00, 6'b00_00_00, 6'b11_00_10,
    6'b11_00_00, 6'b11_00_00, 6'b11_00_00, 6'b11_00_00, 6'b01_00_00
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] r, input logic [N-1:0] f, input int excl);
    for (int off = 0; off < N; off++) begin
      int k;
      k = (m_ptr + off) % N;
      if (r[k] && !f[k] && k != excl) return k;
    end
    return -1;
  endfunction

  task automatic model_update(input logic rst, input logic [N-1:0] r, input logic [N-1:0] h,
                              input logic [N-1:0] f);
    int old_owner;
    int p;
    bit others;
    bit rel;
    if (rst) begin
      m_owner = -1;
      m_burst = 0;
      m_ptr   = 0;
      m_cnt   = 0;
      for (int i = 0; i < N; i++) m_wait[i] = 0;
      return;
    end
    old_owner = m_owner;
    p = -1;
    if (m_owner < 0) begin
      p = model_pick(r, f, -1);
    end else begin
      others = (model_pick(r, f, m_owner) >= 0);
      rel = f[m_owner] || (!r[m_owner] && !h[m_owner]) ||
            (m_burst == MAXB && !h[m_owner] && others);
      if (rel) begin
        p = model_pick(r, f, m_owner);
        if (p < 0) begin
          m_owner = -1;
          m_burst = 0;
        end
      end else if (m_burst < MAXB) begin
        m_burst++;
      end
    end
    if (p >= 0) begin
      m_owner = p;
      m_burst = 1;
      m_ptr   = (p + 1) % N;
      m_cnt   = (m_cnt + 1) % 65536;
    end
    for (int i = 0; i < N; i++) begin
      if (!r[i] || f[i] || (m_owner == i && old_owner != i)) m_wait[i] = 0;
      else if (old_owner != i && m_wait[i] < WMAX) m_wait[i]++;
    end
  endtask

  task automatic compare_model();
    logic [N-1:0] exp_grant;
    logic [N-1:0] exp_starve;
    exp_grant  = (m_owner < 0) ? '0 : N'(1 << m_owner);
    exp_starve = '0;
    for (int i = 0; i < N; i++) if (m_wait[i] >= LIM) exp_starve |= N'(1 << i);
    check("grant",       32'(grant),       32'(exp_grant));
    check("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
    check("grant_idx",   32'(grant_idx),   32'((m_owner < 0) ? 0 : m_owner));
    check("starve",      32'(starve),      32'(exp_starve));
    check("grant_count", 32'(grant_count), 32'(m_cnt));
  endtask

  task automatic apply(input logic rst, input logic [N-1:0] r, input logic [N-1:0] h,
                       input logic [N-1:0] f);
    reset = rst;
    req   = r;
    hold  = h;
    flush = f;
    @(posedge clk);
    model_update(rst, r, h, f);
    #1;
    compare_model();
    cyc++;
    $display("cyc %0d rst=%b req=%b hold=%b flush=%b -> grant=%b idx=%0d starve=%b count=%0d",
             cyc, rst, r, h, f, grant, grant_idx, starve, grant_count);
  endtask

  task automatic do_reset();
    apply(1'b1, 2'b00, 2'b00, 2'b00);
    apply(1'b1, 2'b00, 2'b00, 2'b00);
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    hold  = '0;
    flush = '0;

    // Reset state
    do_reset();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_count", 32'(grant_count), 32'h0);

    // Two contending lanes alternate every MAX_BURST cycles
    for (int k = 1; k <= 9; k++) begin
      apply(1'b0, 2'b11, 2'b00, 2'b00);
      check("t1_grant", 32'(grant), (k <= 4 || k == 9) ? 32'h1 : 32'h2);
    end
    check("t1_count", 32'(grant_count), 32'd3);

    // Sole requester keeps the grant past the quota
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      apply(1'b0, 2'b01, 2'b00, 2'b00);
      check("t2_grant", 32'(grant), 32'h1);
    end
    check("t2_count", 32'(grant_count), 32'd1);

    // Hold on the owner overrides the quota; waiting lane starves
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      apply(1'b0, 2'b11, (k >= 3 && k <= 14) ? 2'b01 : 2'b00, 2'b00);
      if (k == 7)  check("t3_starve7", 32'(starve), 32'h0);
      if (k == 8)  check("t3_starve8", 32'(starve), 32'h2);
      if (k == 14) check("t3_grant14", 32'(grant), 32'h1);
      if (k == 15) check("t3_grant15", 32'(grant), 32'h2);
      if (k == 15) check("t3_starve15", 32'(starve), 32'h0);
    end

    // Flush releases the owner; flushed lanes are skipped; all flushed -> idle
    do_reset();
    apply(1'b0, 2'b11, 2'b00, 2'b00);
    check("t4_grant1", 32'(grant), 32'h1);
    apply(1'b0, 2'b11, 2'b00, 2'b01);
    check("t4_grant2", 32'(grant), 32'h2);
    apply(1'b0, 2'b10, 2'b00, 2'b10);
    check("t4_idle", 32'(grant_valid), 32'h0);
    apply(1'b0, 2'b11, 2'b00, 2'b11);
    check("t4_allflush", 32'(grant), 32'h0);
    apply(1'b0, 2'b11, 2'b00, 2'b00);
    check("t4_regrant", 32'(grant), 32'h1);
    check("t4_count", 32'(grant_count), 32'd3);
    apply(1'b0, 2'b11, 2'b00, 2'b11);
    check("t4_flushowner", 32'(grant), 32'h0);

    // Request drop releases; re-raise re-grants as a new grant
    do_reset();
    apply(1'b0, 2'b01, 2'b00, 2'b00);
    apply(1'b0, 2'b01, 2'b00, 2'b00);
    apply(1'b0, 2'b00, 2'b00, 2'b00);
    check("t5_drop", 32'(grant), 32'h0);
    apply(1'b0, 2'b00, 2'b00, 2'b00);
    apply(1'b0, 2'b00, 2'b00, 2'b00);
    apply(1'b0, 2'b01, 2'b00, 2'b00);
    check("t5_regrant", 32'(grant), 32'h1);
    check("t5_count", 32'(grant_count), 32'd2);
    apply(1'b0, 2'b10, 2'b00, 2'b00);
    check("t5_idx1", 32'(grant_idx), 32'd1);

    // Reset mid-grant clears everything and rotation restarts at lane 0
    do_reset();
    for (int k = 1; k <= 10; k++) apply(1'b0, 2'b11, 2'b01, 2'b00);
    check("t6_starve_pre", 32'(starve), 32'h2);
    apply(1'b1, 2'b11, 2'b01, 2'b00);
    check("t6_grant_rst", 32'(grant), 32'h0);
    check("t6_starve_rst", 32'(starve), 32'h0);
    check("t6_count_rst", 32'(grant_count), 32'h0);
    apply(1'b0, 2'b11, 2'b00, 2'b00);
    check("t6_first", 32'(grant), 32'h1);

    // Mixed directed sequence checked against the model only
    do_reset();
    for (int k = 0; k < 20; k++) begin
      logic [5:0] t;
      t = MIX[k];
      apply(1'b0, t[5:4], t[3:2], t[1:0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
